imem_boot_loader: RTL

//  Boot-time sequencer for the pipelined core's instruction memory.
//  - Receives a program image as a byte stream (valid/ready).
//  - Writes the image word by word into IMEM through its write port.
//  - Holds the core in reset while loading; releases reset and asserts start when done.
//  - Sits between the host byte link and the core top (IMEM write port, core reset/start).

---
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed byte image into IMEM, then releases the core.
// Optional `CHECKSUM_EN adds a trailing XOR checksum byte verified before RUN.
module imem_boot_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        core_start,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t DONE_ST = S_CSUM;
`else
  localparam state_t DONE_ST = S_RUN;
`endif

  localparam logic [16:0] MAX_W = 17'(IMEM_WORDS);

  state_t      r_state;
  logic [15:0] r_count;
  logic [23:0] r_shift;
  logic [1:0]  r_idx;
`ifdef CHECKSUM_EN
  logic [7:0]  r_acc;
`endif

  logic        w_fire;
  logic [15:0] w_n;
  logic [15:0] w_next_wl;

  assign busy      = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
  assign error     = (r_state == S_ERR);
  assign rx_ready  = busy;
  assign w_fire    = rx_valid && rx_ready;
  assign w_n       = {rx_data, r_count[7:0]};
  assign w_next_wl = words_loaded + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_HDR0;
      r_count      <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      core_start   <= 1'b0;
      words_loaded <= '0;
`ifdef CHECKSUM_EN
      r_acc        <= '0;
`endif
    end else begin
      imem_we    <= 1'b0;
      core_reset <= 1'b1;
      core_start <= 1'b0;
      unique case (r_state)
        S_HDR0: if (w_fire) begin
          r_count[7:0] <= rx_data;
          r_state      <= S_HDR1;
        end
        S_HDR1: if (w_fire) begin
          r_count[15:8] <= rx_data;
          if (w_n == 16'd0)
            r_state <= DONE_ST;
          else if ({1'b0, w_n} > MAX_W)
            r_state <= S_ERR;
          else
            r_state <= S_DATA;
        end
        S_DATA: if (w_fire) begin
          r_shift <= {rx_data, r_shift[23:8]};
          r_idx   <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            imem_we      <= 1'b1;
            imem_wdata   <= {rx_data, r_shift};
            imem_addr    <= {14'd0, words_loaded, 2'b00};
            words_loaded <= w_next_wl;
            if (w_next_wl == r_count)
              r_state <= DONE_ST;
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: if (w_fire) begin
          r_state <= (rx_data == r_acc) ? S_RUN : S_ERR;
        end
`endif
        S_RUN: begin
          if (load_req) begin
            r_state      <= S_HDR0;
            words_loaded <= '0;
            imem_addr    <= '0;
            r_idx        <= '0;
            r_count      <= '0;
`ifdef CHECKSUM_EN
            r_acc        <= '0;
`endif
          end else begin
            core_reset <= 1'b0;
            core_start <= 1'b1;
          end
        end
        S_ERR: if (load_req) begin
          r_state      <= S_HDR0;
          words_loaded <= '0;
          imem_addr    <= '0;
          r_idx        <= '0;
          r_count      <= '0;
`ifdef CHECKSUM_EN
          r_acc        <= '0;
`endif
        end
        default: r_state <= S_HDR0;
      endcase
`ifdef CHECKSUM_EN
      // Checksum byte itself also folds in; harmless since the next image clears it.
      if (w_fire)
        r_acc <= r_acc ^ rx_data;
`endif
    end
  end

endmodule
